ondra_tape_conditioner: RTL and testbench
=========================================

// Module: ondra_tape_conditioner
// PURPOSE
//  Conditions the 1-bit cassette signal from the LTC2308 tape ADC before it reaches the core's MGF_IN.
//  - Synchronises the signal into clk_sys and removes glitches with a persistence filter.
//  - Measures half-period lengths between filtered edges.
//  - Runs an activity detector that drives the disk LED and the core's audio pass-through gating.
// PARAMETERS
//  SYNC_STAGES  2       synchroniser flops on tape_in (>=2)
//  GLITCH_CYC   16      cycles a new level must persist before tape_out follows (2 us @ 8 MHz, >=1)
//  IDLE_CYC     800000  cycles without a filtered edge before active drops (100 ms @ 8 MHz)
//  MIN_EDGES    4       consecutive edges, none spaced >= IDLE_CYC, needed to raise active
//  PW_W         16      width of half-period measurement; saturates at 2^PW_W-1
// PORTS
//  clk_sys       in   1     system clock (8 MHz)
//  reset         in   1     synchronous, active-high reset
//  tape_in       in   1     raw tape bit from ADC comparator; asynchronous to clk_sys
//  tape_out      out  1     filtered tape level -> core MGF_IN
//  edge_stb      out  1     one-cycle pulse in the cycle tape_out toggles
//  half_period   out  PW_W  clk_sys cycles between the last two filtered edges
//  period_valid  out  1     one-cycle pulse: half_period just updated with a valid measurement
//  active        out  1     tape signal present (activity FSM in ACTIVE)
// BEHAVIOUR
//  Reset values:
//  - All outputs 0; synchroniser, counters and FSM clear.
//  - The FSM returns to IDLE, and the first-edge flag is set.
//  - Reset asserted mid-operation aborts any pending filter count; no edge_stb is issued.
//  Synchroniser:
//  - SYNC_STAGES-deep shift register; s = last stage.
//  Glitch filter:
//  - gcnt counts cycles with s != tape_out.
//  - If s == tape_out, gcnt <= 0.
//  - If s != tape_out and gcnt == GLITCH_CYC-1, tape_out <= s, gcnt <= 0, edge_stb <= 1.
//  - Otherwise gcnt++.
//  - Latency: a clean step on tape_in is visible on tape_out exactly SYNC_STAGES+GLITCH_CYC clocks later.
//  - Any pulse shorter than GLITCH_CYC synchronised cycles produces no edge.
//  Half-period counter:
//  - pcnt increments every cycle and saturates at 2^PW_W-1; it never wraps.
//  - On edge_stb: half_period <= pcnt+1, saturated; then pcnt <= 0.
//  - period_valid pulses with edge_stb unless the first-edge flag is set. A flagged edge only clears the flag.
//  - The flag is set again at reset and on every ACTIVE->IDLE or IDLE timeout, so gaps are never reported as periods.
//  Activity FSM, states IDLE / ACTIVE, with idle counter icnt:
//  - icnt clears on each edge and otherwise increments, saturating at IDLE_CYC.
//  - IDLE: ecnt counts edges. Reaching MIN_EDGES moves to ACTIVE, with active=1 in the following cycle.
//    icnt reaching IDLE_CYC clears ecnt.
//  - ACTIVE: icnt reaching IDLE_CYC moves to IDLE and clears ecnt; active=0 in the following cycle.
//  - If an edge and timeout fall in the same cycle, the edge wins: icnt clears and the state is held.
//  - active follows the state register directly, with no extra pipeline stage.
//  - tape_out is never gated by active; gating is done downstream.
// TESTING
//  T1 reset: hold reset 3 clks with tape_in=1 -> all outputs 0 on the clk after reset; no edge_stb within SYNC_STAGES clks of release.
//  T2 latency: tape_in 0->1 held -> tape_out=1 and edge_stb=1 exactly at clk 18 (defaults); edge_stb high for 1 clk only.
//  T3 glitch: tape_in 1 for 15 clks then 0 -> tape_out stays 0, no edge_stb. Repeat with 16 clks -> one edge.
//  T4 period: square wave of 100-clk half-periods -> after first edge, period_valid with half_period=100 on each edge.
//      Half-period 70000 with PW_W=16 -> 65535.
//  T5 activity (IDLE_CYC=1000, MIN_EDGES=4):
//      - 3 edges then silence -> active stays 0.
//      - 4 edges -> active=1 the clk after the 4th edge_stb.
//      - Stop toggling -> active=0 1001 clks after the last edge.
//      - The next edge gives no period_valid.
//  T6 collision: edge_stb coincides with icnt reaching IDLE_CYC while ACTIVE -> active remains 1, icnt=0.
//      Assert reset mid-filter count -> no edge emitted.

Source files
------------

// File: rtl/ondra_tape_conditioner.sv
// rtl/ondra_tape_conditioner.sv - tape ADC bit synchroniser, glitch filter, half-period meter and activity detector
`timescale 1ns/1ps

module ondra_tape_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 16,
  parameter int IDLE_CYC    = 800000,
  parameter int MIN_EDGES   = 4,
  parameter int PW_W        = 16
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            tape_in,
  output logic            tape_out,
  output logic            edge_stb,
  output logic [PW_W-1:0] half_period,
  output logic            period_valid,
  output logic            active
);

  // Counter widths; each is at least one bit so degenerate parameters stay legal.
  localparam int GW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int EW = (MIN_EDGES > 1) ? $clog2(MIN_EDGES) : 1;

  localparam logic [GW-1:0]   G_LAST = GW'(GLITCH_CYC - 1);
  localparam logic [IW-1:0]   I_LAST = IW'(IDLE_CYC - 1);
  localparam logic [IW-1:0]   I_MAX  = IW'(IDLE_CYC);
  localparam logic [EW-1:0]   E_LAST = EW'(MIN_EDGES - 1);
  localparam logic [PW_W-1:0] P_MAX  = '1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [GW-1:0]          gcnt;
  logic                   fire;
  logic [PW_W-1:0]        pcnt;
  logic                   first_edge;
  logic [IW-1:0]          icnt;
  logic                   timeout;
  logic [EW-1:0]          ecnt;
  state_t                 state;
  state_t                 state_next;

  assign s = sync_q[SYNC_STAGES-1];

  // The filter commits to a new level once s has disagreed with tape_out for GLITCH_CYC cycles.
  assign fire = (s != tape_out) && (gcnt == G_LAST);

  // Silence has just lasted IDLE_CYC cycles; a coincident edge cancels it.
  assign timeout = !edge_stb && (icnt == I_LAST);

  // Shift the asynchronous tape bit through the synchroniser chain.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tape_in};
    end
  end

  // Persistence filter: count disagreeing cycles, flip tape_out and strobe when the count completes.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      gcnt     <= '0;
      tape_out <= 1'b0;
      edge_stb <= 1'b0;
    end else begin
      edge_stb <= 1'b0;
      if (s == tape_out) begin
        gcnt <= '0;
      end else if (gcnt == G_LAST) begin
        tape_out <= s;
        gcnt     <= '0;
        edge_stb <= 1'b1;
      end else begin
        gcnt <= gcnt + 1'b1;
      end
    end
  end

  // Half-period meter: latch the saturated distance since the previous edge, suppressing edges after a gap.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pcnt         <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      first_edge   <= 1'b1;
    end else begin
      period_valid <= fire && !first_edge && !timeout;
      if (fire) begin
        half_period <= (pcnt == P_MAX) ? P_MAX : pcnt + 1'b1;
        pcnt        <= '0;
      end else if (pcnt != P_MAX) begin
        pcnt <= pcnt + 1'b1;
      end
      if (fire) begin
        first_edge <= 1'b0;
      end else if (timeout) begin
        first_edge <= 1'b1;
      end
    end
  end

  // Idle counter: cleared by every filtered edge, otherwise counts up to IDLE_CYC and holds.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      icnt <= '0;
    end else if (edge_stb) begin
      icnt <= '0;
    end else if (icnt != I_MAX) begin
      icnt <= icnt + 1'b1;
    end
  end

  // Edge counter used while idle; any timeout discards the partial run.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ecnt <= '0;
    end else if (timeout) begin
      ecnt <= '0;
    end else if (edge_stb && (state == ST_IDLE)) begin
      ecnt <= (ecnt == E_LAST) ? '0 : ecnt + 1'b1;
    end
  end

  // Activity FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Activity FSM transitions: enough edges raise activity, a timeout drops it.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (edge_stb && (ecnt == E_LAST)) begin
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (timeout) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Activity FSM output: active is decoded straight from the state register.
  always_comb begin
    active = (state == ST_ACTIVE);
  end

endmodule

// File: tb/tb_ondra_tape_conditioner.sv
// tb/tb_ondra_tape_conditioner.sv - randomized and directed bench with timestamp-based reference model
`timescale 1ns/1ps

module tb_ondra_tape_conditioner;

  localparam int SYNC   = 2;
  localparam int GL     = 16;
  localparam int IDLE   = 1000;
  localparam int MINE   = 4;
  localparam int PW     = 16;
  localparam int HP_MAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tape_in = 1'b0;
  logic          tape_out;
  logic          edge_stb;
  logic [PW-1:0] half_period;
  logic          period_valid;
  logic          active;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ondra_tape_conditioner #(
    .SYNC_STAGES(SYNC),
    .GLITCH_CYC (GL),
    .IDLE_CYC   (IDLE),
    .MIN_EDGES  (MINE),
    .PW_W       (PW)
  ) dut (
    .clk_sys     (clk),
    .reset       (reset),
    .tape_in     (tape_in),
    .tape_out    (tape_out),
    .edge_stb    (edge_stb),
    .half_period (half_period),
    .period_valid(period_valid),
    .active      (active)
  );

  // Reference model: levels delayed through a queue, run length of disagreement,
  // and timestamps (clock numbers) of the last edge / last measurement start.
  bit mq[$];
  bit m_out, m_stb, m_pv, m_active;
  int m_hp;
  int n = 0;
  int run, last_p, last_i, edges;
  bit have_prev, gap;
  bit model_live = 0;
  bit ms, mstb_prev, mtmo, mfire;

  always @(posedge clk) begin
    n++;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
      m_out = 0; run = 0; m_stb = 0; m_pv = 0; m_hp = 0; m_active = 0;
      edges = 0; last_p = n; last_i = n; have_prev = 0; gap = 0;
    end else begin
      ms = mq.pop_front();
      mq.push_back(tape_in);
      mstb_prev = m_stb;
      mtmo = !mstb_prev && (n - last_i == IDLE);
      if (mstb_prev) begin
        last_i = n;
        edges++;
        if (edges >= MINE) m_active = 1;
      end else if (mtmo) begin
        edges = 0;
        m_active = 0;
        gap = 1;
      end
      mfire = 0;
      if (ms == m_out) begin
        run = 0;
      end else begin
        run++;
        if (run == GL) begin
          mfire = 1;
          m_out = ms;
          run = 0;
        end
      end
      m_pv = 0;
      if (mfire) begin
        m_hp = (n - last_p > HP_MAX) ? HP_MAX : n - last_p;
        last_p = n;
        m_pv = have_prev && !gap;
        have_prev = 1;
        gap = 0;
      end
      m_stb = mfire;
    end
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      vectors++;
      if ({tape_out, edge_stb, period_valid, active} !== {m_out, m_stb, m_pv, m_active} ||
          half_period !== PW'(m_hp)) begin
        miscompares++;
        $display("FAIL model clk %0d: dut out/stb/pv/act=%b%b%b%b hp=%0d, model %b%b%b%b hp=%0d",
                 n, tape_out, edge_stb, period_valid, active, half_period,
                 m_out, m_stb, m_pv, m_active, m_hp);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic count_stb(input int k, output int c);
    c = 0;
    repeat (k) begin
      @(negedge clk);
      if (edge_stb) c++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int budget;
    int r;

    // T1 reset with tape_in high
    reset = 1; tape_in = 1;
    clks(3);
    check("t1_tape_out", tape_out, 0);
    check("t1_edge_stb", edge_stb, 0);
    check("t1_half_period", half_period, 0);
    check("t1_period_valid", period_valid, 0);
    check("t1_active", active, 0);
    reset = 0; tape_in = 0;
    count_stb(5, c);
    check("t1_no_stb_after_release", c, 0);
    clks(25);

    // T2 step latency
    tape_in = 1;
    clks(17);
    check("t2_out_at_17", tape_out, 0);
    clks(1);
    check("t2_out_at_18", tape_out, 1);
    check("t2_stb_at_18", edge_stb, 1);
    check("t2_first_edge_no_pv", period_valid, 0);
    clks(1);
    check("t2_stb_one_clk", edge_stb, 0);
    clks(20);
    tape_in = 0;
    clks(40);

    // T3 glitch boundary
    tape_in = 1; clks(15); tape_in = 0;
    count_stb(40, c);
    check("t3_15clk_no_edge", c, 0);
    check("t3_15clk_out", tape_out, 0);
    tape_in = 1; clks(16); tape_in = 0;
    count_stb(10, c);
    check("t3_16clk_one_edge", c, 1);
    clks(40);

    // T4 100-clk half periods
    for (int i = 0; i < 8; i++) begin
      tape_in = ~tape_in;
      clks(18);
      check("t4_stb", edge_stb, 1);
      if (i > 0) begin
        check("t4_half_period", half_period, 100);
        check("t4_period_valid", period_valid, 1);
      end
      clks(82);
    end

    // T4 saturation: 70000-clk half period
    tape_in = 1; clks(18);
    clks(70000 - 18);
    tape_in = 0; clks(18);
    check("t4_sat_stb", edge_stb, 1);
    check("t4_sat_half_period", half_period, 65535);
    check("t4_sat_after_gap_no_pv", period_valid, 0);
    check("t4_sat_active", active, 0);

    // T5 activity
    clks(1200);
    for (int i = 0; i < 3; i++) begin
      tape_in = ~tape_in;
      clks(100);
    end
    clks(1200);
    check("t5_three_edges_inactive", active, 0);
    for (int i = 0; i < 3; i++) begin
      tape_in = ~tape_in;
      clks(100);
    end
    tape_in = ~tape_in;
    clks(18);
    check("t5_fourth_stb", edge_stb, 1);
    check("t5_active_not_yet", active, 0);
    clks(1);
    check("t5_active_after_fourth", active, 1);
    clks(999);
    check("t5_active_at_1000", active, 1);
    clks(1);
    check("t5_inactive_at_1001", active, 0);
    tape_in = ~tape_in;
    clks(18);
    check("t5_next_stb", edge_stb, 1);
    check("t5_next_no_pv", period_valid, 0);

    // T6 edge and timeout in the same cycle
    clks(82);
    for (int i = 0; i < 4; i++) begin
      tape_in = ~tape_in;
      clks(100);
    end
    check("t6_active", active, 1);
    clks(900);
    for (int j = 0; j < 3; j++) begin
      tape_in = ~tape_in;
      clks(18);
      check("t6_collision_stb", edge_stb, 1);
      check("t6_collision_hp", half_period, 1000);
      check("t6_collision_active", active, 1);
      clks(1);
      check("t6_collision_active_next", active, 1);
      clks(981);
    end

    // T6 reset during a pending filter count
    tape_in = ~tape_in;
    clks(10);
    reset = 1; tape_in = 0;
    clks(2);
    reset = 0;
    count_stb(40, c);
    check("t6_reset_no_edge", c, 0);
    check("t6_reset_out", tape_out, 0);
    check("t6_reset_active", active, 0);

    // Randomized phase checked by the model every cycle
    budget = 0;
    while (budget < 6000) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        reset = 1;
        c = $urandom_range(1, 3);
        clks(c);
        reset = 0;
        budget += c;
      end else begin
        if (r < 8)       c = $urandom_range(990, 1010);
        else if (r < 30) c = $urandom_range(1, 6);
        else             c = $urandom_range(12, 40);
        tape_in = ~tape_in;
        clks(c);
        budget += c;
      end
    end
    clks(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
